// File: rtl/tv80_bus_bridge_if.sv
// Signal bundle between the tv80s core, the bridge and its memory / I/O targets.
// master: the bridge itself; slave: everything around it (CPU strobes and target responses).
interface tv80_bus_bridge_if;
  // CPU side
  logic [15:0] cpu_a;
  logic [7:0]  cpu_do;
  logic [7:0]  cpu_di;
  logic        mreq_n;
  logic        iorq_n;
  logic        rd_n;
  logic        wr_n;
  logic        m1_n;
  logic        rfsh_n;
  logic        wait_n;
  // Memory port
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  // I/O port
  logic        io_req;
  logic        io_we;
  logic [7:0]  io_addr;
  logic [7:0]  io_wdata;
  logic        io_ack;
  logic [7:0]  io_rdata;
  logic        bus_err;

  modport master (
    input  cpu_a, cpu_do, mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n,
    output cpu_di, wait_n,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata,
    output io_req, io_we, io_addr, io_wdata,
    input  io_ack, io_rdata,
    output bus_err
  );

  modport slave (
    output cpu_a, cpu_do, mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n,
    input  cpu_di, wait_n,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata,
    input  io_req, io_we, io_addr, io_wdata,
    output io_ack, io_rdata,
    input  bus_err
  );
endinterface

// File: rtl/tv80_bus_bridge.sv
// Turns tv80s Z80 bus strobes into req/ack transactions on a memory port and an 8-bit I/O port,
// stretching the CPU cycle via wait_n and aborting lost transactions after TIMEOUT cycles.
module tv80_bus_bridge #(
  parameter int unsigned TIMEOUT  = 64,
  parameter logic [7:0]  INTA_VEC = 8'hFF,
  parameter logic [7:0]  ERR_DATA = 8'hFF
) (
  input logic              clk,
  input logic              reset_n,
  tv80_bus_bridge_if.master bus
);

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StMemWait, StIoWait, StDone} state_e;

  state_e      state_q;
  logic        armed_q;
  logic [7:0]  cnt_q;
  logic [7:0]  cpu_di_q;
  logic        bus_err_q;
  logic        mem_req_q, mem_we_q;
  logic [15:0] mem_addr_q;
  logic [7:0]  mem_wdata_q;
  logic        io_req_q, io_we_q;
  logic [7:0]  io_addr_q;
  logic [7:0]  io_wdata_q;

  logic mrd, mwr, ird, iwr, inta, act;

  always_comb begin
    mrd  = !bus.mreq_n && !bus.rd_n && bus.rfsh_n;
    mwr  = !bus.mreq_n && !bus.wr_n && bus.rfsh_n;
    ird  = !bus.iorq_n && !bus.rd_n && bus.m1_n;
    iwr  = !bus.iorq_n && !bus.wr_n && bus.m1_n;
    inta = !bus.iorq_n && !bus.m1_n;
    act  = mrd || mwr || ird || iwr || inta;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      armed_q     <= 1'b0;
      cnt_q       <= 8'd0;
      cpu_di_q    <= 8'h00;
      bus_err_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 8'h00;
      io_req_q    <= 1'b0;
      io_we_q     <= 1'b0;
      io_addr_q   <= 8'h00;
      io_wdata_q  <= 8'h00;
    end else begin
      unique case (state_q)
        StIdle: begin
          // armed only rises with strobes idle, so a held strobe never launches a second txn
          if (!act) begin
            armed_q <= 1'b1;
          end else if (armed_q) begin
            armed_q <= 1'b0;
            cnt_q   <= 8'd0;
            if (inta) begin
              cpu_di_q <= INTA_VEC;
              state_q  <= StDone;
            end else if (mrd || mwr) begin
              mem_req_q   <= 1'b1;
              mem_we_q    <= !mrd;
              mem_addr_q  <= bus.cpu_a;
              mem_wdata_q <= bus.cpu_do;
              state_q     <= StMemWait;
            end else begin
              io_req_q   <= 1'b1;
              io_we_q    <= !ird;
              io_addr_q  <= bus.cpu_a[7:0];
              io_wdata_q <= bus.cpu_do;
              state_q    <= StIoWait;
            end
          end
        end
        StMemWait: begin
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            if (!mem_we_q) cpu_di_q <= bus.mem_rdata;
            state_q <= StDone;
          end else if (cnt_q == TimeoutLast) begin
            mem_req_q <= 1'b0;
            bus_err_q <= 1'b1;
            if (!mem_we_q) cpu_di_q <= ERR_DATA;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StIoWait: begin
          if (bus.io_ack) begin
            io_req_q <= 1'b0;
            if (!io_we_q) cpu_di_q <= bus.io_rdata;
            state_q <= StDone;
          end else if (cnt_q == TimeoutLast) begin
            io_req_q  <= 1'b0;
            bus_err_q <= 1'b1;
            if (!io_we_q) cpu_di_q <= ERR_DATA;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StDone: begin
          if (!act) begin
            cnt_q   <= 8'd0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Combinational so the core sees the stretch in the same T-state it asserted the strobe
  assign bus.wait_n = !((state_q == StIdle && armed_q && (mrd || mwr || ird || iwr)) ||
                        state_q == StMemWait || state_q == StIoWait);

  assign bus.cpu_di    = cpu_di_q;
  assign bus.bus_err   = bus_err_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.io_req    = io_req_q;
  assign bus.io_we     = io_we_q;
  assign bus.io_addr   = io_addr_q;
  assign bus.io_wdata  = io_wdata_q;

endmodule

// File: tb/tb_tv80_bus_bridge.sv
// Randomized bench for tv80_bus_bridge: a transaction-level model predicts request duration,
// returned data and error state from the ack delay chosen for each access.
module tb_tv80_bus_bridge;

  localparam int unsigned TIMEOUT  = 64;
  localparam logic [7:0]  INTA_VEC = 8'hFF;
  localparam logic [7:0]  ERR_DATA = 8'hFF;

  localparam int KMrd  = 0;
  localparam int KMwr  = 1;
  localparam int KIrd  = 2;
  localparam int KIwr  = 3;
  localparam int KInta = 4;
  localparam int KRfsh = 5;
  localparam int KIdle = 6;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  tv80_bus_bridge_if bus ();

  tv80_bus_bridge #(
    .TIMEOUT  (TIMEOUT),
    .INTA_VEC (INTA_VEC),
    .ERR_DATA (ERR_DATA)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_di;
  logic       exp_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int kind, input logic [15:0] a, input logic [7:0] d);
    bus.cpu_a  = a;
    bus.cpu_do = d;
    bus.mreq_n = 1'b1;
    bus.iorq_n = 1'b1;
    bus.rd_n   = 1'b1;
    bus.wr_n   = 1'b1;
    bus.m1_n   = 1'b1;
    bus.rfsh_n = 1'b1;
    case (kind)
      KMrd:  begin bus.mreq_n = 1'b0; bus.rd_n = 1'b0; bus.m1_n = 1'($urandom_range(0, 1)); end
      KMwr:  begin bus.mreq_n = 1'b0; bus.wr_n = 1'b0; end
      KIrd:  begin bus.iorq_n = 1'b0; bus.rd_n = 1'b0; end
      KIwr:  begin bus.iorq_n = 1'b0; bus.wr_n = 1'b0; end
      KInta: begin bus.iorq_n = 1'b0; bus.m1_n = 1'b0; end
      KRfsh: begin bus.mreq_n = 1'b0; bus.rfsh_n = 1'b0; end
      default: ;
    endcase
  endtask

  task automatic idle_cycles(input int n);
    drive(KIdle, 16'h0000, 8'h00);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_mem_req"}, bus.mem_req, 0);
    check_eq({tag, "_io_req"}, bus.io_req, 0);
    check_eq({tag, "_wait_n"}, bus.wait_n, 1);
    check_eq({tag, "_cpu_di"}, bus.cpu_di, exp_di);
    check_eq({tag, "_bus_err"}, bus.bus_err, exp_err);
  endtask

  // delay = WAIT cycle on whose closing edge the target acks; above TIMEOUT means never.
  task automatic run_txn(input int kind, input logic [15:0] a, input logic [7:0] d,
                         input logic [7:0] rd, input int delay);
    bit is_mem, is_rd, acked, done;
    int n;
    is_mem = (kind == KMrd) || (kind == KMwr);
    is_rd  = (kind == KMrd) || (kind == KIrd);
    drive(kind, a, d);
    @(negedge clk);
    check_eq("wait_n_strobe", bus.wait_n, 0);
    @(posedge clk);
    #1;
    n = 1;
    acked = 0;
    done = 0;
    while (!done) begin
      bus.mem_ack   = is_mem && (n == delay);
      bus.io_ack    = !is_mem && (n == delay);
      bus.mem_rdata = (n == delay) ? rd : 8'($urandom);
      bus.io_rdata  = (n == delay) ? rd : 8'($urandom);
      @(negedge clk);
      check_eq("wait_n_hold", bus.wait_n, 0);
      if (is_mem) begin
        check_eq("mem_req", bus.mem_req, 1);
        check_eq("io_req_idle", bus.io_req, 0);
        check_eq("mem_we", bus.mem_we, !is_rd);
        check_eq("mem_addr", bus.mem_addr, a);
        if (!is_rd) check_eq("mem_wdata", bus.mem_wdata, d);
      end else begin
        check_eq("io_req", bus.io_req, 1);
        check_eq("mem_req_idle", bus.mem_req, 0);
        check_eq("io_we", bus.io_we, !is_rd);
        check_eq("io_addr", bus.io_addr, a[7:0]);
        if (!is_rd) check_eq("io_wdata", bus.io_wdata, d);
      end
      @(posedge clk);
      #1;
      bus.mem_ack = 1'b0;
      bus.io_ack  = 1'b0;
      if (n == delay) begin
        acked = 1;
        done  = 1;
      end else if (n == int'(TIMEOUT)) begin
        done = 1;
      end
      n++;
    end
    if (acked) begin
      if (is_rd) exp_di = rd;
    end else begin
      exp_err = 1'b1;
      if (is_rd) exp_di = ERR_DATA;
    end
    // strobes still held: bridge must release and not relaunch
    repeat (2) begin
      @(negedge clk);
      check_quiet("post_txn");
      @(posedge clk);
      #1;
    end
    idle_cycles(2);
  endtask

  task automatic run_inta();
    drive(KInta, 16'($urandom), 8'h00);
    @(negedge clk);
    check_eq("inta_wait_n", bus.wait_n, 1);
    @(posedge clk);
    #1;
    exp_di = INTA_VEC;
    @(negedge clk);
    check_quiet("inta");
    @(posedge clk);
    #1;
    idle_cycles(2);
  endtask

  task automatic run_refresh();
    drive(KRfsh, 16'($urandom), 8'h00);
    // stray acks outside a WAIT state must be ignored
    bus.mem_ack   = 1'b1;
    bus.io_ack    = 1'b1;
    bus.mem_rdata = 8'($urandom);
    bus.io_rdata  = 8'($urandom);
    repeat (3) begin
      @(negedge clk);
      check_quiet("rfsh");
      @(posedge clk);
      #1;
      bus.mem_ack = 1'b0;
      bus.io_ack  = 1'b0;
    end
    idle_cycles(2);
  endtask

  task automatic check_reset_vals(input string tag);
    check_quiet(tag);
    check_eq({tag, "_mem_we"}, bus.mem_we, 0);
    check_eq({tag, "_io_we"}, bus.io_we, 0);
    check_eq({tag, "_mem_addr"}, bus.mem_addr, 0);
    check_eq({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    check_eq({tag, "_io_addr"}, bus.io_addr, 0);
    check_eq({tag, "_io_wdata"}, bus.io_wdata, 0);
  endtask

  task automatic run_reset_mid_wait();
    drive(KMrd, 16'hBEEF, 8'h00);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    #2;
    reset_n = 1'b0;
    exp_di  = 8'h00;
    exp_err = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_quiet("rst_held_rd");
      @(posedge clk);
      #1;
    end
    idle_cycles(2);
  endtask

  initial begin
    int kind;
    int r;
    int delay;
    exp_di  = 8'h00;
    exp_err = 1'b0;
    bus.mem_ack   = 1'b0;
    bus.io_ack    = 1'b0;
    bus.mem_rdata = 8'h00;
    bus.io_rdata  = 8'h00;
    drive(KIdle, 16'h0000, 8'h00);
    #3;
    check_reset_vals("reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle_cycles(2);

    run_txn(KMrd, 16'hDCA6, 8'h00, 8'h49, 3);
    run_txn(KMwr, 16'h8000, 8'h5A, 8'h00, 1);
    run_txn(KIrd, 16'h12FE, 8'h00, 8'h3C, 2);
    run_refresh();
    run_inta();
    run_txn(KMrd, 16'h1234, 8'h00, 8'hA5, TIMEOUT);
    run_txn(KMrd, 16'h4321, 8'h00, 8'h77, TIMEOUT + 10);
    run_reset_mid_wait();
    run_txn(KIwr, 16'hAB55, 8'hC3, 8'h00, 1);

    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 5);
      r = $urandom_range(0, 19);
      delay = (r == 0) ? TIMEOUT + 5 : (r == 1) ? TIMEOUT : $urandom_range(1, 6);
      case (kind)
        KInta:   run_inta();
        KRfsh:   run_refresh();
        default: run_txn(kind, 16'($urandom), 8'($urandom), 8'($urandom), delay);
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
